carregador_programa: RTL and testbench

Program loader. It copies a program image from the simulated HD into the instruction memory by driving that memory's write port (address, data, InstrWrite), which is otherwise held inactive.
- Started by the OS controller while the CPU is blocked.
- Reads one 32-bit word per HD (trilha, setor) location and writes it to consecutive instruction addresses starting at 0.
- Signals completion so the controller can release the CPU and deselect the BIOS.

---
 rtl/so_pkg.sv | 18 +
 rtl/carregador_programa_endereco_hd.sv | 37 +++
 rtl/carregador_programa.sv | 139 +++++++++++++
 tb/tb_carregador_programa.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/so_pkg.sv
// Shared definitions for the OS-side hardware blocks: loader state
// encoding and the default field widths of the instruction memory and HD.
package so_pkg;

    localparam int ADDR_W_PADRAO   = 6;
    localparam int DATA_W_PADRAO   = 32;
    localparam int TRILHA_W_PADRAO = 4;
    localparam int SETOR_W_PADRAO  = 6;

    typedef enum logic [2:0] {
        OCIOSO,
        LE_HD,
        ESPERA,
        ESCREVE,
        FIM
    } estado_carga_t;

endpackage

// File: rtl/carregador_programa_endereco_hd.sv
// Registered HD (track, sector) address counter. Loads a start address
// and advances one sector per increment, carrying into the track on wrap.
module endereco_hd
    import so_pkg::*;
#(
    parameter int TRILHA_W = TRILHA_W_PADRAO,
    parameter int SETOR_W  = SETOR_W_PADRAO
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                carrega,
    input  logic                incrementa,
    input  logic [TRILHA_W-1:0] trilha_ini,
    input  logic [SETOR_W-1:0]  setor_ini,
    output logic [TRILHA_W-1:0] trilha,
    output logic [SETOR_W-1:0]  setor
);

    // Address register: load wins over increment; sector wrap bumps the track.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trilha <= '0;
            setor  <= '0;
        end else if (carrega) begin
            trilha <= trilha_ini;
            setor  <= setor_ini;
        end else if (incrementa) begin
            if (setor == '1) begin
                setor  <= '0;
                trilha <= trilha + TRILHA_W'(1);
            end else begin
                setor  <= setor + SETOR_W'(1);
            end
        end
    end

endmodule

// File: rtl/carregador_programa.sv
// Program loader: copies num_palavras words from consecutive HD locations
// into instruction memory addresses 0..num_palavras-1.
module carregador_programa
    import so_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_PADRAO,
    parameter int DATA_W   = DATA_W_PADRAO,
    parameter int TRILHA_W = TRILHA_W_PADRAO,
    parameter int SETOR_W  = SETOR_W_PADRAO,
    parameter int HD_LAT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inicia,
    input  logic [TRILHA_W-1:0] trilha_ini,
    input  logic [SETOR_W-1:0]  setor_ini,
    input  logic [ADDR_W:0]     num_palavras,
    output logic [TRILHA_W-1:0] hd_trilha,
    output logic [SETOR_W-1:0]  hd_setor,
    input  logic [DATA_W-1:0]   hd_dado,
    output logic [ADDR_W-1:0]   instr_ender,
    output logic [DATA_W-1:0]   instr_dado,
    output logic                InstrWrite,
    output logic                ocupado,
    output logic                concluido,
    output logic                erro
);

    localparam int LAT_W = (HD_LAT > 1) ? $clog2(HD_LAT) : 1;

    estado_carga_t     estado, prox_estado;
    logic [ADDR_W:0]   indice, num_q, indice_mais_um;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] ender_q;
    logic [DATA_W-1:0] dado_q;
    logic              pedido_invalido, pedido_vazio;
    logic              carrega_end, avanca_end;

    // Counts above 2^ADDR_W: top bit set together with any lower bit.
    assign pedido_invalido = num_palavras[ADDR_W] && (num_palavras[ADDR_W-1:0] != '0);
    assign pedido_vazio    = (num_palavras == '0);
    assign indice_mais_um  = indice + (ADDR_W+1)'(1);

    endereco_hd #(
        .TRILHA_W (TRILHA_W),
        .SETOR_W  (SETOR_W)
    ) u_endereco (
        .clk        (clk),
        .reset      (reset),
        .carrega    (carrega_end),
        .incrementa (avanca_end),
        .trilha_ini (trilha_ini),
        .setor_ini  (setor_ini),
        .trilha     (hd_trilha),
        .setor      (hd_setor)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox_estado;
    end

    // Next state and outputs; write port is combinational so it drops with reset.
    always_comb begin
        prox_estado = estado;
        InstrWrite  = 1'b0;
        ocupado     = 1'b1;
        concluido   = 1'b0;
        carrega_end = 1'b0;
        avanca_end  = 1'b0;
        instr_ender = ender_q;
        instr_dado  = dado_q;
        unique case (estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (inicia && !pedido_invalido) begin
                    if (pedido_vazio) begin
                        prox_estado = FIM;
                    end else begin
                        prox_estado = LE_HD;
                        carrega_end = 1'b1;
                    end
                end
            end
            LE_HD:  prox_estado = ESPERA;
            ESPERA: if (lat_cnt == '0) prox_estado = ESCREVE;
            ESCREVE: begin
                InstrWrite  = 1'b1;
                instr_ender = indice[ADDR_W-1:0];
                instr_dado  = hd_dado;
                avanca_end  = 1'b1;
                prox_estado = (indice_mais_um == num_q) ? FIM : LE_HD;
            end
            FIM: begin
                concluido   = 1'b1;
                prox_estado = OCIOSO;
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    // Datapath: request latch, word index, latency counter, held write port values, error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            indice  <= '0;
            num_q   <= '0;
            lat_cnt <= '0;
            ender_q <= '0;
            dado_q  <= '0;
            erro    <= 1'b0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (inicia) begin
                        if (pedido_invalido) begin
                            erro <= 1'b1;
                        end else begin
                            erro <= 1'b0;
                            if (!pedido_vazio) begin
                                num_q  <= num_palavras;
                                indice <= '0;
                            end
                        end
                    end
                end
                LE_HD:  lat_cnt <= LAT_W'(HD_LAT - 1);
                ESPERA: if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
                ESCREVE: begin
                    indice  <= indice_mais_um;
                    ender_q <= indice[ADDR_W-1:0];
                    dado_q  <= hd_dado;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_carregador_programa.sv
// Bench for the program loader: two instances (HD latency 1 and 3) fed by
// an HD model whose data appears HD_LAT cycles after the address.
module tb_carregador_programa;

    logic        clk = 1'b0;
    logic        reset;
    logic        inicia       [2];
    logic [3:0]  trilha_ini   [2];
    logic [5:0]  setor_ini    [2];
    logic [6:0]  num_palavras [2];
    logic [3:0]  hd_trilha    [2];
    logic [5:0]  hd_setor     [2];
    logic [31:0] hd_dado      [2];
    logic [5:0]  instr_ender  [2];
    logic [31:0] instr_dado   [2];
    logic        InstrWrite   [2];
    logic        ocupado      [2];
    logic        concluido    [2];
    logic        erro         [2];

    logic [21:0] salt;
    logic [31:0] p1, p2;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    carregador_programa #(.HD_LAT(1)) u0 (
        .clk(clk), .reset(reset), .inicia(inicia[0]),
        .trilha_ini(trilha_ini[0]), .setor_ini(setor_ini[0]), .num_palavras(num_palavras[0]),
        .hd_trilha(hd_trilha[0]), .hd_setor(hd_setor[0]), .hd_dado(hd_dado[0]),
        .instr_ender(instr_ender[0]), .instr_dado(instr_dado[0]), .InstrWrite(InstrWrite[0]),
        .ocupado(ocupado[0]), .concluido(concluido[0]), .erro(erro[0])
    );

    carregador_programa #(.HD_LAT(3)) u1 (
        .clk(clk), .reset(reset), .inicia(inicia[1]),
        .trilha_ini(trilha_ini[1]), .setor_ini(setor_ini[1]), .num_palavras(num_palavras[1]),
        .hd_trilha(hd_trilha[1]), .hd_setor(hd_setor[1]), .hd_dado(hd_dado[1]),
        .instr_ender(instr_ender[1]), .instr_dado(instr_dado[1]), .InstrWrite(InstrWrite[1]),
        .ocupado(ocupado[1]), .concluido(concluido[1]), .erro(erro[1])
    );

    function automatic logic [31:0] tag(input logic [3:0] t, input logic [5:0] s);
        return {salt, t, s};
    endfunction

    // HD model: data for an address becomes visible HD_LAT cycles later.
    always_ff @(posedge clk) begin
        hd_dado[0] <= tag(hd_trilha[0], hd_setor[0]);
        p1         <= tag(hd_trilha[1], hd_setor[1]);
        p2         <= p1;
        hd_dado[1] <= p2;
    end

    task automatic chk(input string nome, input logic [63:0] obs, input logic [63:0] esp);
        total++;
        assert (obs === esp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nome, obs, esp);
        end
    endtask

    // One load on instance k; expected schedule derived from word count and latency.
    task automatic run_load(input int k, input logic [3:0] tr, input logic [5:0] se, input int n);
        int L, tot, w, budget, a;
        bit err;
        L      = (k == 0) ? 1 : 3;
        err    = (n > 64);
        tot    = err ? 0 : ((n == 0) ? 1 : n * (L + 2) + 1);
        budget = tot + 3;
        w      = 0;
        @(negedge clk);
        salt            = 22'($urandom);
        trilha_ini[k]   = tr;
        setor_ini[k]    = se;
        num_palavras[k] = 7'(n);
        inicia[k]       = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= budget; c++) begin
            #1;
            inicia[k]       = (c < tot) ? 1'($urandom) : 1'b0;
            trilha_ini[k]   = 4'($urandom);
            setor_ini[k]    = 6'($urandom);
            num_palavras[k] = 7'($urandom);
            @(negedge clk);
            chk("ocupado", ocupado[k], (c <= tot));
            chk("concluido", concluido[k], (c == tot));
            chk("erro", erro[k], err);
            if (InstrWrite[k] === 1'b1) begin
                if (w >= n) begin
                    chk("extra_write", 1, 0);
                end else begin
                    a = (int'(tr) * 64 + int'(se) + w) % 1024;
                    chk("write_cycle", c, (w + 1) * (L + 2));
                    chk("instr_ender", instr_ender[k], w);
                    chk("instr_dado", instr_dado[k], tag(4'(a / 64), 6'(a % 64)));
                    chk("hd_addr", {hd_trilha[k], hd_setor[k]}, {4'(a / 64), 6'(a % 64)});
                end
                w++;
            end
            @(posedge clk);
        end
        inicia[k] = 1'b0;
        #1;
        chk("write_count", w, err ? 0 : n);
        if (!err && n > 0) begin
            a = (int'(tr) * 64 + int'(se) + n - 1) % 1024;
            chk("held_ender", instr_ender[k], n - 1);
            chk("held_dado", instr_dado[k], tag(4'(a / 64), 6'(a % 64)));
        end
    endtask

    initial begin
        reset = 1'b1;
        salt  = '0;
        for (int k = 0; k < 2; k++) begin
            inicia[k] = 1'b0; trilha_ini[k] = '0; setor_ini[k] = '0; num_palavras[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_InstrWrite", InstrWrite[k], 0);
            chk("rst_ocupado", ocupado[k], 0);
            chk("rst_concluido", concluido[k], 0);
            chk("rst_erro", erro[k], 0);
            chk("rst_ender", instr_ender[k], 0);
            chk("rst_dado", instr_dado[k], 0);
            chk("rst_hd", {hd_trilha[k], hd_setor[k]}, 0);
        end
        @(negedge clk);
        reset = 1'b0;

        run_load(0, 4'd2, 6'd5, 3);
        run_load(0, 4'd15, 6'd62, 4);
        run_load(0, 4'($urandom), 6'($urandom), 0);
        run_load(0, 4'($urandom), 6'($urandom), 65);
        run_load(0, 4'($urandom), 6'($urandom), int'($urandom_range(66, 127)));
        run_load(0, 4'($urandom), 6'($urandom), int'($urandom_range(1, 8)));

        // Reset during the write of word 1 of 4.
        @(negedge clk);
        trilha_ini[0] = 4'($urandom); setor_ini[0] = 6'($urandom);
        num_palavras[0] = 7'd4; inicia[0] = 1'b1;
        @(posedge clk);
        #1 inicia[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_InstrWrite", InstrWrite[0], 1);
        chk("pre_rst_ender", instr_ender[0], 1);
        #1 reset = 1'b1;
        #1;
        chk("async_InstrWrite", InstrWrite[0], 0);
        chk("async_ocupado", ocupado[0], 0);
        chk("async_concluido", concluido[0], 0);
        chk("async_erro", erro[0], 0);
        chk("async_ender", instr_ender[0], 0);
        chk("async_dado", instr_dado[0], 0);
        chk("async_hd", {hd_trilha[0], hd_setor[0]}, 0);
        @(negedge clk);
        reset = 1'b0;

        run_load(0, 4'($urandom), 6'($urandom), 4);
        for (int j = 0; j < 3; j++)
            run_load(0, 4'($urandom), 6'($urandom), int'($urandom_range(0, 12)));
        run_load(0, 4'($urandom), 6'($urandom), 64);
        run_load(1, 4'($urandom), 6'($urandom), 64);
        run_load(1, 4'($urandom), 6'($urandom), int'($urandom_range(1, 10)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
